// File: rtl/pe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pe_pkg
// Description : Shared defaults and payload type for the PE array datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package pe_pkg;

    localparam int DATA_W_DEF = 12;
    localparam int F_INIT_DEF = -4;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] max;
        logic [DATA_W_DEF-1:0] v;
        logic [DATA_W_DEF-1:0] f;
    } pe_data_t;

endpackage
`default_nettype wire

// File: rtl/pe_delay_stage.sv
`default_nettype none
// ============================================================================
// Module      : pe_delay_stage
// Description : One {valid, max, v, f} register stage of the PE delay line.
// Revision    : 1.0 - initial release
// ============================================================================
module pe_delay_stage
    import pe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int F_INIT = F_INIT_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [3*DATA_W-1:0]   in_data,
    output logic                  out_valid,
    output logic [3*DATA_W-1:0]   out_data
);

    // Empty slot: max=0, v=0, f=F_INIT (f occupies the low field).
    localparam logic [3*DATA_W-1:0] c_EMPTY = {{(2*DATA_W){1'b0}}, DATA_W'(F_INIT)};

    logic                r_valid;
    logic [3*DATA_W-1:0] r_data;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_valid <= 1'b0;
            r_data  <= c_EMPTY;
        end else if (en) begin
            r_valid <= in_valid;
            r_data  <= in_data;
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/pe_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : pe_delay_line
// Description : Programmable-length delay line for PE {max, v, f} triples.
// Revision    : 1.0 - initial release
// ============================================================================
module pe_delay_line
    import pe_pkg::*;
#(
    parameter  int DATA_W = DATA_W_DEF,
    parameter  int DEPTH  = 128,
    parameter  int F_INIT = F_INIT_DEF,
    localparam int LEN_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              flush,
    input  logic [LEN_W-1:0]  len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] max_in,
    input  logic [DATA_W-1:0] v_in,
    input  logic [DATA_W-1:0] f_in,
    output logic              out_valid,
    output logic [DATA_W-1:0] max_out,
    output logic [DATA_W-1:0] v_out,
    output logic [DATA_W-1:0] f_out,
    output logic              primed,
    output logic [LEN_W-1:0]  len_q
);

    localparam int                  SEL_W       = $clog2(DEPTH);
    localparam logic [LEN_W-1:0]    c_DEPTH_LEN = LEN_W'(DEPTH);
    localparam logic [3*DATA_W-1:0] c_EMPTY     = {{(2*DATA_W){1'b0}}, DATA_W'(F_INIT)};

    logic                r_stg_valid [DEPTH];
    logic [3*DATA_W-1:0] r_stg_data  [DEPTH];

    logic [3*DATA_W-1:0] w_head_data;
    logic [LEN_W-1:0]    w_len_legal;
    logic [SEL_W-1:0]    w_sel;
    logic [LEN_W-1:0]    r_len_q;
    logic [LEN_W-1:0]    r_fill_cnt;

    // Invalid inputs enter as a clean empty slot rather than whatever is on the bus.
    assign w_head_data = in_valid ? {max_in, v_in, f_in} : c_EMPTY;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                pe_delay_stage #(
                    .DATA_W (DATA_W),
                    .F_INIT (F_INIT)
                ) u_stage (
                    .clk       (clk),
                    .reset     (reset),
                    .en        (en),
                    .flush     (flush),
                    .in_valid  (in_valid),
                    .in_data   (w_head_data),
                    .out_valid (r_stg_valid[gi]),
                    .out_data  (r_stg_data[gi])
                );
            end else begin : g_body
                pe_delay_stage #(
                    .DATA_W (DATA_W),
                    .F_INIT (F_INIT)
                ) u_stage (
                    .clk       (clk),
                    .reset     (reset),
                    .en        (en),
                    .flush     (flush),
                    .in_valid  (r_stg_valid[gi-1]),
                    .in_data   (r_stg_data[gi-1]),
                    .out_valid (r_stg_valid[gi]),
                    .out_data  (r_stg_data[gi])
                );
            end
        end
    endgenerate

    // Zero or out-of-range requests fall back to the full physical depth.
    assign w_len_legal = ((len == '0) || (len > c_DEPTH_LEN)) ? c_DEPTH_LEN : len;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_len_q    <= c_DEPTH_LEN;
            r_fill_cnt <= '0;
        end else if (flush) begin
            r_len_q    <= w_len_legal;
            r_fill_cnt <= '0;
        end else if (en && (r_fill_cnt != r_len_q)) begin
            r_fill_cnt <= r_fill_cnt + LEN_W'(1);
        end
    end

    // len_q is always 1..DEPTH, so the tap index stays in range.
    assign w_sel = SEL_W'(r_len_q - LEN_W'(1));

    assign out_valid                 = r_stg_valid[w_sel];
    assign {max_out, v_out, f_out}   = r_stg_data[w_sel];
    assign primed                    = (r_fill_cnt == r_len_q);
    assign len_q                     = r_len_q;

endmodule
`default_nettype wire

// File: tb/tb_pe_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : tb_pe_delay_line
// Description : Self-checking bench for pe_delay_line (DEPTH=8, DATA_W=12).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_delay_line;
    import pe_pkg::*;

    localparam int DEPTH = 8;
    localparam int LEN_W = 4;

    typedef struct packed {
        logic     valid;
        pe_data_t d;
    } ent_t;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             en = 1'b0;
    logic             flush = 1'b0;
    logic [LEN_W-1:0] len = '0;
    logic             in_valid = 1'b0;
    logic [11:0]      max_in = '0;
    logic [11:0]      v_in = '0;
    logic [11:0]      f_in = '0;
    logic             out_valid;
    logic [11:0]      max_out;
    logic [11:0]      v_out;
    logic [11:0]      f_out;
    logic             primed;
    logic [LEN_W-1:0] len_q;

    always #5 clk = ~clk;

    pe_delay_line #(
        .DATA_W (12),
        .DEPTH  (DEPTH),
        .F_INIT (-4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .flush     (flush),
        .len       (len),
        .in_valid  (in_valid),
        .max_in    (max_in),
        .v_in      (v_in),
        .f_in      (f_in),
        .out_valid (out_valid),
        .max_out   (max_out),
        .v_out     (v_out),
        .f_out     (f_out),
        .primed    (primed),
        .len_q     (len_q)
    );

    // Reference: log of every advance since the last flush/reset; the output is
    // the entry pushed len_q advances ago, or an empty slot if none exists.
    ent_t  log_q[$];
    int    adv;
    int    lenq;
    int    n_assert = 0;
    int    n_fail   = 0;
    string phase    = "init";

    function automatic ent_t empty_ent();
        ent_t e;
        e.valid = 1'b0;
        e.d.max = '0;
        e.d.v   = '0;
        e.d.f   = 12'hFFC;
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s/%s: observed=%0h expected=%0h", phase, tag, obs, exp);
        end
    endtask

    task automatic cycle(input logic r, input logic e, input logic fl, input logic [LEN_W-1:0] l,
                         input logic iv, input logic [11:0] m, input logic [11:0] v, input logic [11:0] f);
        ent_t ex;
        ent_t nw;
        reset = r; en = e; flush = fl; len = l; in_valid = iv;
        max_in = m; v_in = v; f_in = f;
        @(posedge clk);
        if (r) begin
            log_q.delete(); adv = 0; lenq = DEPTH;
        end else if (fl) begin
            log_q.delete(); adv = 0;
            lenq = (int'(l) == 0 || int'(l) > DEPTH) ? DEPTH : int'(l);
        end else if (e) begin
            if (iv) begin
                nw.valid = 1'b1; nw.d.max = m; nw.d.v = v; nw.d.f = f;
            end else begin
                nw = empty_ent();
            end
            log_q.push_back(nw);
            adv++;
        end
        #1;
        ex = (adv >= lenq) ? log_q[adv-lenq] : empty_ent();
        check("out_valid", 32'(out_valid), 32'(ex.valid));
        check("max_out",   32'(max_out),   32'(ex.d.max));
        check("v_out",     32'(v_out),     32'(ex.d.v));
        check("f_out",     32'(f_out),     32'(ex.d.f));
        check("primed",    32'(primed),    32'(adv >= lenq));
        check("len_q",     32'(len_q),     32'(lenq));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 1, 0, '0, 0, '0, '0, '0);
    endtask

    task automatic push(input logic [11:0] m, input logic [11:0] v, input logic [11:0] f);
        cycle(0, 1, 0, '0, 1, m, v, f);
    endtask

    task automatic do_flush(input logic [LEN_W-1:0] l);
        cycle(0, 0, 1, l, 0, '0, '0, '0);
    endtask

    initial begin
        adv = 0; lenq = DEPTH;

        phase = "reset";
        cycle(1, 0, 0, '0, 0, '0, '0, '0);
        cycle(1, 1, 1, 4'd3, 1, 12'd1, 12'd2, 12'd3);

        phase = "idle_fill";
        idle(10);

        phase = "len3_pair";
        do_flush(4'd3);
        push(12'd5, 12'd6, 12'd7);
        push(12'd8, 12'd9, 12'd10);
        idle(5);

        phase = "len3_stall";
        do_flush(4'd3);
        push(12'd11, 12'd12, 12'd13);
        push(12'd14, 12'd15, 12'd16);
        cycle(0, 0, 0, 4'd7, 1, 12'h111, 12'h222, 12'h333);
        cycle(0, 0, 0, 4'd1, 0, 12'h444, 12'h555, 12'h666);
        idle(5);

        phase = "len0";
        do_flush(4'd0);
        push(12'hABC, 12'h123, 12'h800);
        idle(9);

        phase = "len12";
        do_flush(4'd12);
        push(12'hFFF, 12'h000, 12'h7FF);
        idle(9);

        phase = "flush_drop";
        do_flush(4'd8);
        push(12'd21, 12'd22, 12'd23);
        idle(1);
        cycle(0, 1, 1, 4'd2, 1, 12'd31, 12'd32, 12'd33);
        idle(4);

        phase = "random";
        for (int i = 0; i < 120; i++) begin
            cycle(0, ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0), LEN_W'($urandom),
                  $urandom_range(0, 1) == 1, 12'($urandom), 12'($urandom), 12'($urandom));
        end

        phase = "reset_mid";
        do_flush(4'd8);
        for (int i = 0; i < 4; i++) push(12'(i + 1), 12'(i + 2), 12'(i + 3));
        cycle(1, 1, 0, '0, 1, 12'h0AA, 12'h0BB, 12'h0CC);
        for (int i = 0; i < 9; i++) push(12'(40 + i), 12'(50 + i), 12'(60 + i));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
